// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier back end.
// Holds the FP32 field layout, the result class encoding, the flag bit
// positions, the buffered entry layout and the classification helper.
package fp_mul_pkg;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int FRAC_W  = 23;
    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    localparam int FLG_NAN  = 2;
    localparam int FLG_OVRF = 1;
    localparam int FLG_UDRF = 0;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic [31:0] fp_z;
        logic [2:0]  flags;
        logic [2:0]  r_mode;
        fp_class_e   cls;
    } fp_entry_t;

    // Class is taken from the bit pattern only; the multiplier's NAN flag is
    // carried separately so the monitor can spot disagreements between them.
    // Subnormals fall through to normal.
    function automatic fp_class_e fp_classify(input logic [31:0] z);
        logic [7:0]        e;
        logic [FRAC_W-1:0] f;
        fp_class_e         c;
        e = z[EXP_MSB:EXP_LSB];
        f = z[FRAC_W-1:0];
        if (e == EXP_ALL1)
            c = (f != '0) ? CLS_NAN : CLS_INF;
        else if (e == 8'h00 && f == '0)
            c = CLS_ZERO;
        else
            c = CLS_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/fp_fifo_sync.sv
// Generic single-clock FIFO.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   push, wdata  - write request and data (ignored while full)
//   pop, rdata   - read request (ignored while empty) and head data
//   count        - occupancy, full / empty status
// rdata is read straight from storage at the read pointer; storage itself is
// not reset, so callers must qualify rdata with !empty.
module fp_fifo_sync #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Result buffer behind the FP32 multiplier.
// Captures each product with its {NAN, ovrf, udrf} flags, rounding mode and
// class into a DEPTH-entry FIFO presented on a valid/ready port, and keeps
// saturating statistics for the system monitor.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   in_valid, fp_Z, ovrf, udrf, NAN,
//   r_mode                           - multiplier result (never stalls)
//   in_ready                         - advisory not-full
//   out_valid, out_ready, out_data,
//   out_flags, out_rmode, out_class  - head entry and handshake
//   count                            - occupancy
//   ovrf_cnt, udrf_cnt, nan_cnt      - accepted entries per flag
//   drop_cnt, overrun                - entries lost to a full FIFO
//   clr_cnt                          - clears statistics and overrun
module fp_mul_result_buffer
    import fp_mul_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                fp_Z,
    input  logic                       ovrf,
    input  logic                       udrf,
    input  logic                       NAN,
    input  logic [2:0]                 r_mode,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_flags,
    output logic [2:0]                 out_rmode,
    output logic [1:0]                 out_class,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           ovrf_cnt,
    output logic [CNT_W-1:0]           udrf_cnt,
    output logic [CNT_W-1:0]           nan_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       overrun,
    input  logic                       clr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fp_entry_t wr_entry;
    fp_entry_t rd_entry;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;

    always_comb begin
        wr_entry                 = '0;
        wr_entry.fp_z            = fp_Z;
        wr_entry.flags[FLG_NAN]  = NAN;
        wr_entry.flags[FLG_OVRF] = ovrf;
        wr_entry.flags[FLG_UDRF] = udrf;
        wr_entry.r_mode          = r_mode;
        wr_entry.cls             = fp_classify(fp_Z);
    end

    assign push = in_valid && !full;
    assign pop  = out_valid && out_ready;

    fp_fifo_sync #(
        .WIDTH ($bits(fp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Storage is not reset, so the head fields are forced to zero while
    // empty; this keeps stale pre-reset data off the output port.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = out_valid ? rd_entry.fp_z   : '0;
    assign out_flags = out_valid ? rd_entry.flags  : '0;
    assign out_rmode = out_valid ? rd_entry.r_mode : '0;
    assign out_class = out_valid ? rd_entry.cls    : '0;

    // Clear has priority over any same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            ovrf_cnt <= '0;
            udrf_cnt <= '0;
            nan_cnt  <= '0;
            drop_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            if (push && ovrf && ovrf_cnt != CNT_MAX)
                ovrf_cnt <= ovrf_cnt + CNT_W'(1);
            if (push && udrf && udrf_cnt != CNT_MAX)
                udrf_cnt <= udrf_cnt + CNT_W'(1);
            if (push && NAN && nan_cnt != CNT_MAX)
                nan_cnt <= nan_cnt + CNT_W'(1);
            // A pop in the same cycle does not make room for this entry.
            if (in_valid && full) begin
                overrun <= 1'b1;
                if (drop_cnt != CNT_MAX)
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
module tb_fp_mul_result_buffer;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] fp_Z = '0;
    logic        ovrf = 1'b0, udrf = 1'b0, NAN = 1'b0;
    logic [2:0]  r_mode = '0;
    logic        in_ready, out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_flags, out_rmode;
    logic [1:0]  out_class;
    logic [3:0]  count;
    logic [CNT_W-1:0] ovrf_cnt, udrf_cnt, nan_cnt, drop_cnt;
    logic        overrun;
    logic        clr_cnt = 1'b0;

    fp_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fp_Z(fp_Z),
        .ovrf(ovrf), .udrf(udrf), .NAN(NAN), .r_mode(r_mode),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .out_rmode(out_rmode),
        .out_class(out_class), .count(count), .ovrf_cnt(ovrf_cnt),
        .udrf_cnt(udrf_cnt), .nan_cnt(nan_cnt), .drop_cnt(drop_cnt),
        .overrun(overrun), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] z;
        logic [2:0]  f;
        logic [2:0]  rm;
        logic [1:0]  c;
    } m_t;

    m_t q[$];
    int m_ovrf = 0, m_udrf = 0, m_nan = 0, m_drop = 0;
    bit m_overrun = 1'b0;

    function automatic logic [1:0] ref_class(input logic [31:0] z);
        int e;
        int fr;
        e  = int'(z[30:23]);
        fr = int'(z[22:0]);
        if (e == 255) return (fr != 0) ? 2'd3 : 2'd2;
        if (e == 0 && fr == 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    bit m_full, m_push, m_pop;
    m_t m_e;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ovrf = 0; m_udrf = 0; m_nan = 0; m_drop = 0; m_overrun = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_pop  = (q.size() != 0) && out_ready;
            m_push = in_valid && !m_full;
            if (clr_cnt) begin
                m_ovrf = 0; m_udrf = 0; m_nan = 0; m_drop = 0; m_overrun = 0;
            end else begin
                if (m_push && ovrf) m_ovrf = sat(m_ovrf);
                if (m_push && udrf) m_udrf = sat(m_udrf);
                if (m_push && NAN)  m_nan  = sat(m_nan);
                if (in_valid && m_full) begin
                    m_drop = sat(m_drop);
                    m_overrun = 1'b1;
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                m_e.z = fp_Z; m_e.f = {NAN, ovrf, udrf}; m_e.rm = r_mode; m_e.c = ref_class(fp_Z);
                q.push_back(m_e);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", count, q.size());
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() != DEPTH);
            chk("out_data", out_data, (q.size() != 0) ? q[0].z : 32'h0);
            chk("out_flags", out_flags, (q.size() != 0) ? q[0].f : 3'h0);
            chk("out_rmode", out_rmode, (q.size() != 0) ? q[0].rm : 3'h0);
            chk("out_class", out_class, (q.size() != 0) ? q[0].c : 2'h0);
            chk("ovrf_cnt", ovrf_cnt, m_ovrf);
            chk("udrf_cnt", udrf_cnt, m_udrf);
            chk("nan_cnt", nan_cnt, m_nan);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("overrun", overrun, m_overrun);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] z, input logic o, input logic u,
                            input logic n, input logic [2:0] rm);
        in_valid = 1'b1; fp_Z = z; ovrf = o; udrf = u; NAN = n; r_mode = rm;
        step();
        in_valid = 1'b0; ovrf = 1'b0; udrf = 1'b0; NAN = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] z;
        z = $urandom;
        case ($urandom_range(0, 5))
            1: z = {z[31], 31'h0};
            2: z = {z[31], 8'hFF, 23'h0};
            3: z = {z[31], 8'hFF, z[22:1], 1'b1};
            4: z = {z[31], 8'h00, z[22:0]};
            default: ;
        endcase
        return z;
    endfunction

    initial begin
        repeat (2) step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst count", count, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst overrun", overrun, 0);

        // single push of 1.0
        push_one(32'h3F800000, 0, 0, 0, 3'b000);
        chk("t1 out_valid", out_valid, 1);
        chk("t1 out_data", out_data, 32'h3F800000);
        chk("t1 out_class", out_class, 0);
        chk("t1 count", count, 1);
        pop_one();
        chk("t1 drained", out_valid, 0);

        // specials with flags
        push_one(32'h7F800000, 1, 0, 0, 3'b001);
        push_one(32'h00000000, 0, 1, 0, 3'b010);
        push_one(32'h7FC00000, 0, 0, 1, 3'b011);
        chk("t2 ovrf_cnt", ovrf_cnt, 1);
        chk("t2 udrf_cnt", udrf_cnt, 1);
        chk("t2 nan_cnt", nan_cnt, 1);
        chk("t2 class inf", out_class, 2);
        chk("t2 flags inf", out_flags, 3'b010);
        pop_one();
        chk("t2 class zero", out_class, 1);
        chk("t2 flags zero", out_flags, 3'b001);
        pop_one();
        chk("t2 class nan", out_class, 3);
        chk("t2 rmode nan", out_rmode, 3'b011);
        pop_one();

        // overflow: 10 pushes into 8 entries
        for (int i = 0; i < 10; i++) push_one(32'd100 + i, 0, 0, 0, 3'b100);
        chk("t3 count", count, 8);
        chk("t3 in_ready", in_ready, 0);
        chk("t3 drop_cnt", drop_cnt, 2);
        chk("t3 overrun", overrun, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t3 drain order", out_data, 32'd100 + i);
            pop_one();
        end
        chk("t3 empty", out_valid, 0);

        // streaming across pointer wrap
        for (int i = 0; i < 5; i++) push_one(32'd200 + i, 0, 0, 0, 3'b101);
        for (int i = 0; i < 20; i++) begin
            chk("t4 head", out_data, 32'd200 + i);
            chk("t4 count", count, 5);
            in_valid = 1'b1; fp_Z = 32'd205 + i; out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4 drain", out_data, 32'd220 + i);
            pop_one();
        end

        // reset mid-operation
        for (int i = 0; i < 6; i++) push_one(32'h40000000 + i, 1, 1, 1, 3'b110);
        chk("t5 count before", count, 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5 count", count, 0);
        chk("t5 out_valid", out_valid, 0);
        chk("t5 ovrf_cnt", ovrf_cnt, 0);
        chk("t5 drop_cnt", drop_cnt, 0);
        chk("t5 overrun", overrun, 0);
        chk("t5 out_data", out_data, 0);

        // saturation then clear
        in_valid = 1'b1; ovrf = 1'b1; out_ready = 1'b1; fp_Z = 32'h7F800000;
        repeat (CNT_MAX) step();
        chk("t6 ovrf sat", ovrf_cnt, 16'hFFFF);
        step();
        chk("t6 ovrf hold", ovrf_cnt, 16'hFFFF);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t6 ovrf clr", ovrf_cnt, 0);
        in_valid = 1'b0; ovrf = 1'b0;
        step();
        out_ready = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            fp_Z      = rand_fp();
            ovrf      = $urandom_range(0, 3) == 0;
            udrf      = $urandom_range(0, 3) == 0;
            NAN       = $urandom_range(0, 3) == 0;
            r_mode    = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) == 0);
            clr_cnt   = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; reset = 1'b0;
        step();
        step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
